fifoctl_rwp: RTL

//  Single-clock FIFO controller that drives an external ramrwpx-style RAM (1-cycle registered read, no read enable).
//  It generates write/read addresses, tracks RAM occupancy, and hides the read latency behind a 2-entry show-ahead

---
 rtl/fifoctl_rwp.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fifoctl_rwp.sv
// ----------------------------------------------------------------------------
// fifoctl_rwp
//
// Single-clock FIFO controller for an external RAM with a 1-cycle registered
// read port and no read enable. It owns the write/read pointers and the RAM
// occupancy count. A 2-entry show-ahead output buffer (obuf) hides the RAM
// read latency, so the consumer sees a valid/ready stream at one word per
// cycle.
//
// Ports
//   clk      : single clock (the RAM's wclk/rclk are tied to it as well)
//   rst_n    : asynchronous reset, active low
//   clr      : synchronous flush; clears all state including ovf
//   push     : write request
//   din      : write data
//   full     : RAM holds DEPTH words (registered)
//   ovf      : sticky flag, set by a push while full
//   ovld     : dout valid
//   ordy     : consumer ready; a word is popped when ovld & ordy
//   dout     : head word (show-ahead)
//   lvl      : total words held (RAM + obuf + read in flight), registered
//   ram_we   : RAM write enable
//   ram_wa   : RAM write address
//   ram_di   : RAM write data
//   ram_ra   : RAM read address
//   ram_do   : RAM read data, valid the cycle after the read address
// ----------------------------------------------------------------------------
module fifoctl_rwp #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    output logic               full,
    output logic               ovf,
    output logic               ovld,
    input  logic               ordy,
    output logic [WIDTH-1:0]   dout,
    output logic [ADDRBIT+1:0] lvl,
    output logic               ram_we,
    output logic [ADDRBIT-1:0] ram_wa,
    output logic [WIDTH-1:0]   ram_di,
    output logic [ADDRBIT-1:0] ram_ra,
    input  logic [WIDTH-1:0]   ram_do
);

    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);
    localparam logic [ADDRBIT-1:0] PTR_ONE   = ADDRBIT'(1);
    localparam logic [ADDRBIT:0]   DEPTH_CNT = (ADDRBIT + 1)'(DEPTH);
    localparam logic [ADDRBIT:0]   CNT_ONE   = (ADDRBIT + 1)'(1);

    // Pointers wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [ADDRBIT-1:0] next_ptr(input logic [ADDRBIT-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + PTR_ONE;
    endfunction

    logic [ADDRBIT-1:0] wptr_q, wptr_d;
    logic [ADDRBIT-1:0] rptr_q, rptr_d;
    logic [ADDRBIT:0]   ram_cnt_q, ram_cnt_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         obuf_cnt_q, obuf_cnt_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic               ovld_q, ovld_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic [ADDRBIT+1:0] lvl_q, lvl_d;

    logic               we;
    logic               pop;
    logic               issue;
    logic               cap;
    logic [1:0]         occ;

    always_comb begin
        // A flush cycle ignores both the write and the read issue.
        we    = push & ~full_q & ~clr;
        pop   = ovld_q & ordy;
        occ   = obuf_cnt_q + {1'b0, inflight_q};
        // Issue only if the word will have a free obuf slot when it lands;
        // a pop this cycle frees one, which keeps the stream bubble-free.
        issue = ~clr & (ram_cnt_q != '0) & ((occ - {1'b0, pop}) < 2'd2);
        cap   = inflight_q & ~clr;

        wptr_d     = we    ? next_ptr(wptr_q) : wptr_q;
        rptr_d     = issue ? next_ptr(rptr_q) : rptr_q;
        inflight_d = issue;

        case ({we, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // obuf: head_q is the visible word, tail_q the second entry.
        head_d     = head_q;
        tail_d     = tail_q;
        obuf_cnt_d = obuf_cnt_q;
        case ({pop, cap})
            2'b01: begin
                if (obuf_cnt_q == 2'd0) begin
                    head_d     = ram_do;
                    obuf_cnt_d = 2'd1;
                end else begin
                    tail_d     = ram_do;
                    obuf_cnt_d = 2'd2;
                end
            end
            2'b10: begin
                if (obuf_cnt_q == 2'd2) begin
                    head_d = tail_q;
                end
                obuf_cnt_d = obuf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Count unchanged; the captured word joins behind whatever
                // remains after the pop.
                if (obuf_cnt_q == 2'd1) begin
                    head_d = ram_do;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_do;
                end
            end
            default: ;
        endcase

        ovf_d = ovf_q | (push & full_q);

        if (clr) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            obuf_cnt_d = 2'd0;
            head_d     = '0;
            tail_d     = '0;
            ovf_d      = 1'b0;
        end

        ovld_d = (obuf_cnt_d != 2'd0);
        full_d = (ram_cnt_d == DEPTH_CNT);
        lvl_d  = {1'b0, ram_cnt_d}
               + {{ADDRBIT{1'b0}}, obuf_cnt_d}
               + {{(ADDRBIT + 1){1'b0}}, inflight_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            obuf_cnt_q <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            ovld_q     <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            lvl_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            obuf_cnt_q <= obuf_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ovld_q     <= ovld_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            lvl_q      <= lvl_d;
        end
    end

    assign full   = full_q;
    assign ovf    = ovf_q;
    assign ovld   = ovld_q;
    assign dout   = head_q;
    assign lvl    = lvl_q;
    assign ram_we = we;
    assign ram_wa = wptr_q;
    assign ram_di = din;
    assign ram_ra = rptr_q;

endmodule
